// File: rtl/serial_tx_arbiter.sv
// ============================================================================
// serial_tx_arbiter: round-robin arbiter sharing one serial TX line among
// N_REQ byte requesters. Optional even parity bit via SERIAL_TX_PARITY_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int BAUD_DIV  = 3,
  parameter int STOP_BITS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] data_in,
  output logic [N_REQ-1:0]   grant,
  output logic               tx,
  output logic               busy,
  output logic [2:0]         src
);

  localparam int       BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam [2:0]     STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [2:0]    src_q, src_d;
`ifdef SERIAL_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic       w_found_hi, w_found_lo;
  logic [2:0] w_sel_hi, w_sel_lo, w_sel;
  logic [7:0] w_sel_byte;
  logic       w_bit_end;

  // Winner is the lowest requester above ptr, else the lowest at or below it.
  always_comb begin
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_sel_hi   = 3'd0;
    w_sel_lo   = 3'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (i > int'(ptr_q)) begin
          w_found_hi = 1'b1;
          w_sel_hi   = 3'(i);
        end else begin
          w_found_lo = 1'b1;
          w_sel_lo   = 3'(i);
        end
      end
    end
    w_sel = w_found_hi ? w_sel_hi : w_sel_lo;
  end

  always_comb begin
    w_sel_byte = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_sel == 3'(i)) w_sel_byte = data_in[8*i +: 8];
    end
  end

  assign w_bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    ptr_d    = ptr_q;
    src_d    = src_q;
`ifdef SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif
    grant    = '0;
    case (state_q)
      S_IDLE: begin
        // Grant is suppressed while reset is held so nothing leaks out.
        if ((|req) && !rst) begin
          for (int i = 0; i < N_REQ; i++) grant[i] = (w_sel == 3'(i));
          shift_d  = w_sel_byte;
          src_d    = w_sel;
          ptr_d    = w_sel;
`ifdef SERIAL_TX_PARITY_EN
          parity_d = ^w_sel_byte;
`endif
          baud_d   = '0;
          bit_d    = 3'd0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          baud_d  = '0;
          shift_d = {shift_q[6:0], 1'b0};
          if (bit_q == 3'd7) begin
            bit_d = 3'd0;
`ifdef SERIAL_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = 3'd0;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      ptr_q    <= 3'(N_REQ - 1);
      src_q    <= 3'd0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      ptr_q    <= ptr_d;
      src_q    <= src_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // tx decodes straight from the async-reset state so a reset forces idle-high at once.
  always_comb begin
    tx = 1'b1;
    case (state_q)
      S_START:  tx = 1'b0;
      S_DATA:   tx = shift_q[7];
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: tx = parity_q;
`endif
      default:  tx = 1'b1;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign src  = src_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_tx_arbiter.sv
// ============================================================================
// tb_serial_tx_arbiter: directed self-checking bench for serial_tx_arbiter.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_tx_arbiter;

  localparam int N  = 4;
  localparam int BD = 3;
  localparam int SB = 2;
`ifdef SERIAL_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB    = 1 + 8 + PB + SB;
  localparam int FRAME = NB * BD;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] data_in = '0;
  logic [N-1:0]   grant;
  logic           tx;
  logic           busy;
  logic [2:0]     src;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int g_prev = 0;
  int g_now  = 0;

  serial_tx_arbiter #(.N_REQ(N), .BAUD_DIV(BD), .STOP_BITS(SB)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .data_in (data_in),
    .grant   (grant),
    .tx      (tx),
    .busy    (busy),
    .src     (src)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic logic [NB-1:0] frame_bits(input logic [7:0] b);
    logic [NB-1:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[1+k] = b[7-k];
`ifdef SERIAL_TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  // Waits for a grant at the sampling point; the idle-high line is checked there too.
  task automatic wait_grant(input string tag, input logic [N-1:0] exp, output int gcyc);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (grant != '0) break;
    end
    check_val({tag, "_grant"}, grant, exp);
    check_val({tag, "_idle"}, {busy, tx}, 2'b01);
    gcyc = cyc;
  endtask

  task automatic drive_req(input logic [N-1:0] r);
    @(posedge clk);
    #1 req = r;
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b, input logic [N-1:0] pulse);
    logic [NB-1:0] f;
    f = frame_bits(b);
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      check_val({tag, "_bit"}, {busy, tx}, {1'b1, f[c/BD]});
      if (pulse != '0 && c == 3) req = pulse;
      if (pulse != '0 && c == FRAME - 6) req = '0;
    end
  endtask

  initial begin
    logic [N-1:0] rr_exp [5];
    logic [7:0]   rr_byte [5];
    logic [7:0]   ab;
    rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // reset state, with requests present that must not be granted
    req = 4'b1111;
    @(negedge clk);
    check_val("rst_grant", grant, 4'b0000);
    check_val("rst_line", {busy, tx}, 2'b01);
    check_val("rst_src", src, 3'd0);

    // single frame from requester 0
    data_in = {8'h81, 8'h5A, 8'h3C, 8'hA5};
    @(posedge clk);
    #1 rst = 1'b0;
    req = 4'b0001;
    wait_grant("first", 4'b0001, g_now);
    drive_req(4'b0000);
    @(negedge clk);
    check_val("first_src", src, 3'd0);
    check_val("first_start", {busy, tx}, 2'b10);
    // remaining frame cycles after the START sample just taken
    begin
      logic [NB-1:0] f;
      f = frame_bits(8'hA5);
      for (int c = 1; c < FRAME; c++) begin
        @(negedge clk);
        check_val("first_bit", {busy, tx}, {1'b1, f[c/BD]});
      end
    end
    @(negedge clk);
    check_val("first_end", {busy, tx, grant}, {2'b01, 4'b0000});

    // round robin with all requesters held high after a fresh reset
    data_in = {8'h81, 8'h5A, 8'h3C, 8'h07};
    rr_byte = '{8'h07, 8'h3C, 8'h5A, 8'h81, 8'h07};
    @(posedge clk);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      g_prev = g_now;
      wait_grant("rr", rr_exp[g], g_now);
      if (g > 0) check_val("rr_spacing", g_now - g_prev, FRAME + 1);
      if (g == 4) drive_req(4'b0000);
      check_frame("rr", rr_byte[g], 4'b0000);
    end

    // wrap: after requester 2, requests 0 and 2 -> 0 wins
    data_in = {8'h81, 8'h5A, 8'h3C, 8'hA5};
    drive_req(4'b0100);
    wait_grant("wrap_a", 4'b0100, g_now);
    drive_req(4'b0101);
    check_frame("wrap_a", 8'h5A, 4'b0000);
    wait_grant("wrap_b", 4'b0001, g_now);
    drive_req(4'b0000);
    check_frame("wrap_b", 8'hA5, 4'b0000);
    check_val("wrap_src", src, 3'd0);

    // request raised and dropped during busy is ignored
    drive_req(4'b0010);
    wait_grant("ign", 4'b0010, g_now);
    drive_req(4'b0000);
    check_frame("ign", 8'h3C, 4'b1000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("ign_idle", {busy, tx, grant}, {2'b01, 4'b0000});
    end

    // reset during DATA bit 4 of 0x07 (that bit is 0)
    data_in = {8'h81, 8'h5A, 8'h3C, 8'h07};
    drive_req(4'b0001);
    wait_grant("mid", 4'b0001, g_now);
    drive_req(4'b0000);
    for (int c = 0; c < BD * 5 + 1; c++) @(negedge clk);
    check_val("mid_pre", {busy, tx}, 2'b10);
    #1 rst = 1'b1;
    #1;
    check_val("mid_rst", {busy, tx, grant}, {2'b01, 4'b0000});
    req = 4'b0010;
    @(negedge clk);
    check_val("mid_hold", {busy, tx, grant}, {2'b01, 4'b0000});
    @(posedge clk);
    #1 rst = 1'b0;
    wait_grant("post", 4'b0010, g_now);
    drive_req(4'b0000);
    @(negedge clk);
    check_val("post_src", src, 3'd1);
    ab = 8'h3C;
    begin
      logic [NB-1:0] f;
      f = frame_bits(ab);
      for (int c = 1; c < FRAME; c++) begin
        @(negedge clk);
        check_val("post_bit", {busy, tx}, {1'b1, f[c/BD]});
      end
    end
    @(negedge clk);
    check_val("post_end", {busy, tx}, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
- Shares one serial TX line between N_REQ byte requesters using round-robin arbitration.
- Serializes the granted byte as: start bit (0), 8 data bits MSB first, optional even-parity bit, STOP_BITS stop bits (1).
- Line idles high.
- Sits on the transmit side of the link whose far end is the team's serial receiver.
- Is the single owner of the tx wire.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- BAUD_DIV, 3, clk cycles per serial bit (>=1).
- STOP_BITS, 2, stop bits per frame (1..3).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous active-high reset.
- req  in  N_REQ  per-requester transmit request, level.
- data_in  in  8*N_REQ  byte for requester i at bits [8i+7:8i].
- grant  out  N_REQ  one-hot, one-cycle pulse; the byte of the granted requester is captured that cycle.
- tx  out  1  serial line.
- busy  out  1  high from the cycle after grant through the last stop-bit cycle.
- src  out  3  index of the requester currently or last granted.

Behaviour:
Reset (async, immediate):
- tx=1, grant=0, busy=0, src=0, state=IDLE, bit/baud counters=0.
- Round-robin pointer = N_REQ-1, so requester 0 wins first.

States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.

IDLE:
- tx=1, busy=0.
- If any req is high in a cycle, select the first requester at or after ptr+1 (mod N_REQ) with req=1.
- In that same cycle, pulse grant[sel]=1 and latch data_in[sel] into the shift register.
- Also in that cycle: src<=sel, ptr<=sel, parity<=XOR of the byte.
- Next cycle: state=START.
- If no req is high: no grant, stay in IDLE.

Bit timing:
- Each bit holds tx for exactly BAUD_DIV cycles, counted by the baud counter (0..BAUD_DIV-1).
- State advances when the counter reaches BAUD_DIV-1.

Per-state output:
- START: tx=0.
- DATA: tx=shift[7]; shift left after each bit; 8 bits.
- PARITY: tx=parity.
- STOP: tx=1 for STOP_BITS bits.

Frame and handshake:
- busy=1 in START, DATA, PARITY and STOP.
- Frame length = (1+8+1+STOP_BITS)*BAUD_DIV cycles; 36 with defaults.
- After the last STOP cycle the block returns to IDLE.
- Arbitration restarts in that first IDLE cycle, giving at least one extra idle-high cycle between frames.
- Requesters hold req and data_in stable until they see grant, then drop req the next cycle.
- A req still high one cycle after its grant counts as a new request.

Arbitration and ignored inputs:
- req and data_in changes during busy are ignored.
- Only requesters with req=1 in the IDLE evaluation cycle compete.
- grant is never asserted while busy.
- grant is at most one-hot.

Reset mid-frame:
- Frame aborted, tx forced to 1 immediately.
- No grant is issued until rst is deasserted and an IDLE cycle evaluates req.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined: the PARITY state is present, the parity bit is even (XOR of the 8 data bits), and the frame is 12 bits with defaults.
- Undefined: the PARITY state is removed (DATA -> STOP directly), and the frame is (1+8+STOP_BITS)*BAUD_DIV cycles; 33 with defaults.
- All other timing is unchanged.

Test Plan:
- Reset, then req=4'b0001, data0=8'hA5 (SERIAL_TX_PARITY_EN defined) -> grant=0001 for one cycle.
  - Next cycle tx=0 for 3 cycles, then bits 1,0,1,0,0,1,0,1 at 3 cycles each, parity 0, stop 1 for 6 cycles; busy high for 36 cycles; src=0.
- req=4'b1111 held continuously, grants taken in order -> grant sequence 0001,0010,0100,1000,0001.
  - Consecutive grant pulses are exactly 37 cycles apart.
- After requester 2 is granted, req=4'b0101 -> next grant is 0001 (search from index 3 wraps to 0), not 0100.
- Assert rst during DATA bit 4 -> tx=1 in the same cycle, before the next clk edge; busy=0, grant=0.
  - After release, req=4'b0010 is granted first by pointer rule only if requester 0 has no request; src=1.
- data0=8'h07 with SERIAL_TX_PARITY_EN -> parity bit 1; rebuild without the macro -> no parity bit, busy width 33 cycles, tx high immediately after the last data bit.
- req pulses change during busy (req=4'b1000 raised then dropped before frame end) -> no grant issued; tx stays high in the following IDLE cycle.
